// File: rtl/rx_att_sched.sv
// Sequencer sharing one DS3502 writer across the three RX attenuators: writes
// changed channel values in turn, skipping unchanged ones, with ack/transfer timeouts.
module rx_att_sched #(
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned XFER_TIMEOUT = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] rx_ch1_att,
  input  logic [7:0] rx_ch2_att,
  input  logic [7:0] rx_ch3_att,
  output logic       busy,
  output logic       done,
  output logic [2:0] err,
  output logic       dev_load,
  output logic [7:0] dev_r,
  output logic [1:0] dev_sel,
  input  logic       dev_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, FINISH} state_t;

  localparam logic [15:0] ACK_LIM  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] XFER_LIM = 16'(XFER_TIMEOUT - 1);

  state_t          state_q;
  logic [1:0]      ch_q;
  logic [2:0][7:0] shadow_q;
  logic [2:0][7:0] last_q;
  logic [2:0][7:0] pend_val_q;
  logic [2:0]      last_valid_q;
  logic            pend_q;
  logic [15:0]     cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            dev_load_q;
  logic [2:0]      err_q;
  logic [7:0]      dev_r_q;
  logic [1:0]      dev_sel_q;

  logic [2:0][7:0] in_vals;
  logic [2:0][7:0] start_vals;
  logic            start_now;
  logic            start_fire;
  logic            advance;
  logic            adv_last;
  logic            adv_fire;
  logic [1:0]      adv_ch;
  logic [7:0]      adv_val;

  // The skip decision for the channel being entered is made on the edge into
  // ISSUE, so dev_load can be a registered pulse during the ISSUE cycle itself.
  always_comb begin
    in_vals    = {rx_ch3_att, rx_ch2_att, rx_ch1_att};
    start_vals = (state_q == FINISH && !load) ? pend_val_q : in_vals;
    start_now  = (load && state_q == IDLE) || (state_q == FINISH && (load || pend_q));
    start_fire = !(last_valid_q[0] && start_vals[0] == last_q[0]);
    adv_ch     = ch_q + 2'd1;
    adv_last   = (ch_q == 2'd2);
    adv_val    = '0;
    adv_fire   = 1'b0;
    case (adv_ch)
      2'd1: begin
        adv_val  = shadow_q[1];
        adv_fire = !(last_valid_q[1] && shadow_q[1] == last_q[1]);
      end
      2'd2: begin
        adv_val  = shadow_q[2];
        adv_fire = !(last_valid_q[2] && shadow_q[2] == last_q[2]);
      end
      default: ;
    endcase
    advance = (state_q == ISSUE && !dev_load_q)
           || (state_q == WAIT_ACK && !dev_busy && cnt_q == ACK_LIM)
           || (state_q == WAIT_DONE && (!dev_busy || cnt_q == XFER_LIM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      shadow_q     <= '0;
      last_q       <= '0;
      pend_val_q   <= '0;
      last_valid_q <= '0;
      pend_q       <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dev_load_q   <= 1'b0;
      err_q        <= '0;
      dev_r_q      <= '0;
      dev_sel_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      dev_load_q <= 1'b0;
      if (load && (state_q == ISSUE || state_q == WAIT_ACK || state_q == WAIT_DONE)) begin
        pend_q     <= 1'b1;
        pend_val_q <= in_vals;
      end
      case (state_q)
        ISSUE: begin
          if (dev_load_q) begin
            state_q <= WAIT_ACK;
            cnt_q   <= '0;
          end
        end
        WAIT_ACK: begin
          if (dev_busy) begin
            state_q <= WAIT_DONE;
            cnt_q   <= '0;
          end else if (cnt_q == ACK_LIM) begin
            err_q[ch_q]        <= 1'b1;
            last_valid_q[ch_q] <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (!dev_busy) begin
            last_q[ch_q]       <= shadow_q[ch_q];
            last_valid_q[ch_q] <= 1'b1;
          end else if (cnt_q == XFER_LIM) begin
            err_q[ch_q]        <= 1'b1;
            last_valid_q[ch_q] <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        FINISH: begin
          if (!start_now) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
      if (advance) begin
        if (adv_last) begin
          state_q   <= FINISH;
          busy_q    <= pend_q | load;
          done_q    <= 1'b1;
          dev_sel_q <= '0;
          dev_r_q   <= '0;
        end else begin
          state_q    <= ISSUE;
          ch_q       <= adv_ch;
          dev_sel_q  <= adv_ch;
          dev_r_q    <= adv_val;
          dev_load_q <= adv_fire;
        end
      end
      if (start_now) begin
        state_q    <= ISSUE;
        shadow_q   <= start_vals;
        err_q      <= '0;
        ch_q       <= '0;
        busy_q     <= 1'b1;
        pend_q     <= 1'b0;
        dev_sel_q  <= '0;
        dev_r_q    <= start_vals[0];
        dev_load_q <= start_fire;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign dev_load = dev_load_q;
  assign dev_r    = dev_r_q;
  assign dev_sel  = dev_sel_q;

endmodule

// File: tb/tb_rx_att_sched.sv
// Bench for rx_att_sched: vector table of load sequences against a DS3502 writer
// model, with a write scoreboard plus pending-load and mid-sequence reset cases.
module tb_rx_att_sched;

  localparam int unsigned BUSY_LEN = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] rx_ch1_att;
  logic [7:0] rx_ch2_att;
  logic [7:0] rx_ch3_att;
  logic       busy;
  logic       done;
  logic [2:0] err;
  logic       dev_load;
  logic [7:0] dev_r;
  logic [1:0] dev_sel;
  logic       dev_busy;

  always #5 clk = ~clk;

  rx_att_sched #(.ACK_TIMEOUT(16), .XFER_TIMEOUT(300)) dut (
    .clk(clk), .rst(rst), .load(load),
    .rx_ch1_att(rx_ch1_att), .rx_ch2_att(rx_ch2_att), .rx_ch3_att(rx_ch3_att),
    .busy(busy), .done(done), .err(err),
    .dev_load(dev_load), .dev_r(dev_r), .dev_sel(dev_sel), .dev_busy(dev_busy)
  );

  // Writer model: busy for BUSY_LEN cycles after dev_load; can ignore ch0 or hang on ch2.
  logic        nack0;
  logic        hang2;
  logic        hung;
  logic [15:0] wcnt;
  assign dev_busy = (wcnt != 16'd0) || hung;

  always @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      hung <= 1'b0;
    end else begin
      if (!hang2) hung <= 1'b0;
      if (wcnt != 16'd0) wcnt <= wcnt - 16'd1;
      if (dev_load && !(nack0 && dev_sel == 2'd0)) begin
        if (hang2 && dev_sel == 2'd2) hung <= 1'b1;
        else wcnt <= 16'(BUSY_LEN);
      end
    end
  end

  typedef struct {
    logic [1:0] sel;
    logic [7:0] r;
  } wr_t;

  typedef struct {
    logic [2:0][7:0] vals;
    logic            nack0;
    logic            hang2;
    logic [2:0]      wr_mask;
    logic [2:0]      exp_err;
    int unsigned     lat;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  w;
  vec_t vt [9];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dev_load) begin
      chk("dev_load_while_dev_busy", dev_busy, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got sel %0d r %0h expected no write", dev_sel, dev_r);
      end else begin
        w = exp_q.pop_front();
        chk("write_sel", dev_sel, w.sel);
        chk("write_r", dev_r, w.r);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_dev_load"}, dev_load, 0);
    chk({tag, "_dev_sel"}, dev_sel, 0);
    chk({tag, "_dev_r"}, dev_r, 0);
  endtask

  task automatic drive_vals(input logic [2:0][7:0] v);
    rx_ch1_att = v[0];
    rx_ch2_att = v[1];
    rx_ch3_att = v[2];
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   cyc;
    int   bcnt;
    bit   got;
    v     = vt[idx];
    nack0 = v.nack0;
    hang2 = v.hang2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++)
      if (v.wr_mask[i]) exp_q.push_back('{sel: 2'(i), r: v.vals[i]});
    drive_vals(v.vals);
    load = 1'b1;
    cyc  = 0;
    bcnt = 0;
    got  = 1'b0;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      load = 1'b0;
      cyc++;
      if (busy) bcnt++;
      if (done) got = 1'b1;
    end
    chk($sformatf("v%0d_done_seen", idx), got, 1);
    chk($sformatf("v%0d_latency", idx), cyc, v.lat);
    chk($sformatf("v%0d_busy_cycles", idx), bcnt, v.lat - 1);
    chk($sformatf("v%0d_err", idx), err, v.exp_err);
    chk($sformatf("v%0d_writes_left", idx), exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //            vals {ch3,ch2,ch1}           nack hang mask    err     lat
    vt[0] = '{vals: {8'h30, 8'h20, 8'h10}, nack0: 0, hang2: 0, wr_mask: 3'b111, exp_err: 3'b000, lat: 307};
    vt[1] = '{vals: {8'h30, 8'h20, 8'h10}, nack0: 0, hang2: 0, wr_mask: 3'b000, exp_err: 3'b000, lat: 4};
    vt[2] = '{vals: {8'h30, 8'h21, 8'h10}, nack0: 0, hang2: 0, wr_mask: 3'b010, exp_err: 3'b000, lat: 105};
    vt[3] = '{vals: {8'h30, 8'h21, 8'h11}, nack0: 1, hang2: 0, wr_mask: 3'b001, exp_err: 3'b001, lat: 20};
    vt[4] = '{vals: {8'h30, 8'h21, 8'h11}, nack0: 0, hang2: 0, wr_mask: 3'b001, exp_err: 3'b000, lat: 105};
    vt[5] = '{vals: {8'h31, 8'h21, 8'h11}, nack0: 0, hang2: 1, wr_mask: 3'b100, exp_err: 3'b100, lat: 305};
    vt[6] = '{vals: {8'h31, 8'h21, 8'h11}, nack0: 0, hang2: 0, wr_mask: 3'b100, exp_err: 3'b000, lat: 105};
    vt[7] = '{vals: {8'h90, 8'h80, 8'h70}, nack0: 0, hang2: 0, wr_mask: 3'b111, exp_err: 3'b000, lat: 307};
    vt[8] = '{vals: {8'h90, 8'h80, 8'h70}, nack0: 0, hang2: 0, wr_mask: 3'b111, exp_err: 3'b000, lat: 307};

    rst   = 1'b1;
    load  = 1'b0;
    nack0 = 1'b0;
    hang2 = 1'b0;
    drive_vals('0);
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);
    run_vec(7);

    // Load A, then B and C during ch0's write: A then C, B dropped, no idle gap.
    repeat (2) @(negedge clk);
    exp_q.push_back('{sel: 2'd0, r: 8'h40});
    exp_q.push_back('{sel: 2'd1, r: 8'h50});
    exp_q.push_back('{sel: 2'd2, r: 8'h60});
    exp_q.push_back('{sel: 2'd0, r: 8'h42});
    exp_q.push_back('{sel: 2'd1, r: 8'h52});
    exp_q.push_back('{sel: 2'd2, r: 8'h62});
    drive_vals({8'h60, 8'h50, 8'h40});
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    drive_vals({8'h61, 8'h51, 8'h41});
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    drive_vals({8'h62, 8'h52, 8'h42});
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("pend_first_done", done, 1);
    chk("pend_busy_at_done", busy, 1);
    @(negedge clk);
    chk("pend_restart_dev_load", dev_load, 1);
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("pend_second_done", done, 1);
    chk("pend_err", err, 0);
    chk("pend_writes_left", exp_q.size(), 0);

    // Reset during ch0 WAIT_DONE; afterwards unchanged values are rewritten.
    repeat (2) @(negedge clk);
    exp_q.push_back('{sel: 2'd0, r: 8'h71});
    drive_vals({8'h90, 8'h80, 8'h71});
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    exp_q.delete();
    run_vec(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
